// File: rtl/qed_commit_tracker.sv
// qed_commit_tracker: SQED commit point selection plus original/duplicate retire tracking and QED check qualification
//   in : clk, rst (async active-low), sif_trigger, pipe_empty, retire_valid, retire_is_dup, retire_is_nop
//   out: sif_state, sif_commit, sif_commit_pulsed, qed_num_orig, qed_num_dup, qed_check_valid, cnt_overflow, order_err
module qed_commit_tracker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sif_trigger,
    input  logic             pipe_empty,
    input  logic             retire_valid,
    input  logic             retire_is_dup,
    input  logic             retire_is_nop,
    output logic [1:0]       sif_state,
    output logic             sif_commit,
    output logic             sif_commit_pulsed,
    output logic [CNT_W-1:0] qed_num_orig,
    output logic [CNT_W-1:0] qed_num_dup,
    output logic             qed_check_valid,
    output logic             cnt_overflow,
    output logic             order_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, COMMIT = 2'd1, TRACK = 2'd2} state_t;
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_orig, r_dup;
    logic             r_ovf, r_oerr;
    logic             w_active, w_cnt, w_inc_orig, w_inc_dup, w_orig_max, w_dup_max;
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:          w_next = (sif_trigger && pipe_empty && !retire_valid) ? COMMIT : IDLE;
            COMMIT, TRACK: w_next = TRACK;
            default:       w_next = IDLE;
        endcase
    end
    assign w_active   = (r_state == COMMIT) || (r_state == TRACK);
    // once overflow is flagged both counters freeze, so nothing further is counted
    assign w_cnt      = w_active && retire_valid && !retire_is_nop && !r_ovf;
    assign w_inc_orig = w_cnt && !retire_is_dup;
    assign w_inc_dup  = w_cnt && retire_is_dup;
    assign w_orig_max = &r_orig;
    assign w_dup_max  = &r_dup;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_orig  <= '0;
            r_dup   <= '0;
            r_ovf   <= 1'b0;
            r_oerr  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_inc_orig && !w_orig_max)
                r_orig <= r_orig + CNT_W'(1);
            if (w_inc_dup && !w_dup_max)
                r_dup <= r_dup + CNT_W'(1);
            if ((w_inc_orig && w_orig_max) || (w_inc_dup && w_dup_max))
                r_ovf <= 1'b1;
            if (w_inc_dup && (r_dup >= r_orig))
                r_oerr <= 1'b1;
        end
    end
    assign sif_state         = r_state;
    assign sif_commit        = w_active;
    assign sif_commit_pulsed = (r_state == COMMIT);
    assign qed_num_orig      = r_orig;
    assign qed_num_dup       = r_dup;
    assign cnt_overflow      = r_ovf;
    assign order_err         = r_oerr;
    assign qed_check_valid   = w_active && (r_orig == r_dup) && (r_orig != '0) && pipe_empty && !r_ovf && !r_oerr;
endmodule

// File: doc/qed_commit_tracker.md
Name: qed_commit_tracker

Overview:
- Producer of the SQED commit-tracking signals that the formal harness binds to inside the DUT wrapper: sif_commit, sif_commit_pulsed, sif_state, qed_num_orig, qed_num_dup and qed_check_valid.
- Selects the symbolic-initial-state commit point T_C, then counts retired original and duplicate instructions.
- Declares a QED consistency check valid when both halves have retired equal, non-zero counts with the pipeline drained.

Parameters:
- CNT_W, 8, width of the original and duplicate retire counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-low reset.
- sif_trigger  in  1  request to take the commit point; left free in formal.
- pipe_empty  in  1  no instruction in flight between decode and writeback.
- retire_valid  in  1  one instruction retires this cycle.
- retire_is_dup  in  1  retiring instruction is a duplicate (upper register/memory half); qualified by retire_valid.
- retire_is_nop  in  1  retiring instruction is a QED-inserted NOP (0x13); not counted.
- sif_state  out  2  FSM state: 0 IDLE, 1 COMMIT, 2 TRACK; 3 unused.
- sif_commit  out  1  commit point has been taken (sticky until reset).
- sif_commit_pulsed  out  1  high exactly in the T_C cycle.
- qed_num_orig  out  CNT_W  original instructions retired since T_C.
- qed_num_dup  out  CNT_W  duplicate instructions retired since T_C.
- qed_check_valid  out  1  register/memory halves must be QED-consistent now.
- cnt_overflow  out  1  sticky: a counter would have wrapped.
- order_err  out  1  sticky: a duplicate retired with no outstanding original.

Behaviour:
- Reset (rst=0, asynchronous) outputs and state:
  - sif_state=IDLE; sif_commit=0; qed_num_orig=0; qed_num_dup=0; cnt_overflow=0; order_err=0.
  - sif_commit_pulsed=0 and qed_check_valid=0 (both are derived from state).
  - Reset mid-operation discards all progress; there is no partial-state retention.
- FSM:
  - IDLE -> COMMIT on the edge where sif_trigger && pipe_empty && !retire_valid. Otherwise stay in IDLE; retirements in IDLE are ignored.
  - COMMIT -> TRACK unconditionally after one cycle.
  - TRACK holds until reset. sif_trigger is ignored outside IDLE.
  - State 3 is unreachable; if it is entered, the next state is IDLE.
- Decoded outputs:
  - sif_commit_pulsed = (sif_state==COMMIT).
  - sif_commit = (sif_state==COMMIT || sif_state==TRACK), registered with the state.
- Counting:
  - Active in COMMIT and TRACK.
  - On a posedge with retire_valid && !retire_is_nop:
    - if retire_is_dup, increment qed_num_dup;
    - else increment qed_num_orig.
  - New count is visible the cycle after the retire.
  - NOPs are never counted.
- Order check:
  - A counted duplicate retire while qed_num_dup >= qed_num_orig sets order_err.
  - That duplicate is still counted.
- Overflow:
  - An increment of a counter equal to 2^CNT_W-1 sets cnt_overflow.
  - From that edge on, both counters freeze: no further increments, no wrap.
- qed_check_valid (combinational from registered state plus pipe_empty) requires all of:
  - sif_commit;
  - qed_num_orig == qed_num_dup;
  - qed_num_orig != 0;
  - pipe_empty;
  - !cnt_overflow;
  - !order_err.
- Simultaneous events:
  - sif_trigger with retire_valid in IDLE: the commit is not taken that cycle.
  - Retire in the COMMIT cycle: counted.
  - Overflow and order error on the same edge: both flags set.
- Latency:
  - T_C is 1 cycle after the qualifying trigger.
  - Check valid appears at the earliest 1 cycle after the balancing duplicate retires.

Test Plan:
1. Reset then trigger: rst low 2 cycles, release; sif_trigger=1, pipe_empty=1, no retire -> next cycle sif_state=1, sif_commit_pulsed=1, sif_commit=1; following cycle sif_state=2, pulsed=0, sif_commit stays 1.
2. Balanced stream: after T_C retire orig, orig, dup, dup (nop between each), then pipe_empty=1 -> counts 2/2, qed_check_valid=1; nops leave counts unchanged; valid=0 while pipe_empty=0.
3. Blocked trigger: sif_trigger=1 with retire_valid=1 or pipe_empty=0 in IDLE -> stays IDLE, sif_commit=0; retires in IDLE leave counts 0.
4. Order error: after T_C, a duplicate retires first -> qed_num_dup=1, order_err=1; a later orig brings counts to 1/1 yet qed_check_valid stays 0.
5. Overflow with CNT_W=2: 3 orig + 3 dup give valid=1; a 4th orig -> cnt_overflow=1, qed_num_orig stays 3, qed_check_valid=0, further retires ignored.
6. Reset mid-TRACK with counts 5/4: assert rst asynchronously between edges -> all outputs 0 immediately; after release, a fresh trigger produces a new T_C pulse.
